// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide unit: op codes, funct codes, FSM states.
package sm_muldiv_pkg;

  // Operation select driven by the control unit alongside start
  localparam logic [1:0] MD_MULTU = 2'd0;
  localparam logic [1:0] MD_MULT  = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_DIV   = 2'd3;

  // R-type funct codes decoded by the control unit for HI/LO instructions
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Per-operation context captured at the accepting edge
  typedef struct packed {
    logic is_div;
    logic neg_res;   // product / quotient must be negated
    logic neg_rem;   // remainder takes dividend sign
    logic div_zero;  // divisor was zero
  } md_ctx_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/sm_md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring compare-subtract-shift for divide.
module sm_md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: add multiplicand when the low multiplier bit is set, then shift the pair right.
  // Divide: shift the partial remainder left, subtract the divisor when it fits, shift in the quotient bit.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, operand});
    diff    = rem_sh[WIDTH-1:0] - operand;
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      next_hi = ge ? diff : rem_sh[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; WIDTH+1 edges per operation.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  md_ctx_t          ctx;
  md_ctx_t          ctx_new;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  sm_md_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (ctx.is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Operand magnitudes and sign context for an incoming request
  always_comb begin
    sign_a           = op_is_signed(op) & srcA[WIDTH-1];
    sign_b           = op_is_signed(op) & srcB[WIDTH-1];
    mag_a            = sign_a ? (~srcA) + WIDTH'(1) : srcA;
    mag_b            = sign_b ? (~srcB) + WIDTH'(1) : srcB;
    ctx_new.is_div   = op_is_div(op);
    ctx_new.neg_res  = sign_a ^ sign_b;
    ctx_new.neg_rem  = op_is_div(op) & sign_a;
    ctx_new.div_zero = op_is_div(op) & (srcB == '0);
  end

  // Sign fix-up of the unsigned iteration result; divide-by-zero forces an all-ones quotient
  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (ctx.is_div) begin
      if (ctx.neg_rem) fix_hi = (~acc_hi) + WIDTH'(1);
      if (ctx.div_zero)     fix_lo = '1;
      else if (ctx.neg_res) fix_lo = (~acc_lo) + WIDTH'(1);
    end else begin
      if (ctx.neg_res) prod = (~prod) + PW'(1);
      fix_hi = prod[PW-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      ctx     <= '0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (hiWe) hi <= wd;
          if (loWe) lo <= wd;
          if (start) begin
            state   <= MD_RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            divZero <= 1'b0;
            ctx     <= ctx_new;
            acc_hi  <= '0;
            // Divide iterates on the dividend, multiply shifts through the multiplier
            acc_lo  <= ctx_new.is_div ? mag_a : mag_b;
            operand <= ctx_new.is_div ? mag_b : mag_a;
          end
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= MD_FIX;
        end
        MD_FIX: begin
          hi      <= fix_hi;
          lo      <= fix_lo;
          divZero <= ctx.div_zero;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// Bench for sm_muldiv: WIDTH=32 directed cases plus WIDTH=8 and WIDTH=32 random traffic,
// both checked every cycle against a countdown model built on plain integer arithmetic.
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=32 instance signals
  logic        rst32 = 1'b0, s_start = 1'b0, s_hwe = 1'b0, s_lwe = 1'b0;
  logic [1:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0, s_wd = '0;
  logic        s_busy, s_done, s_dz;
  logic [31:0] s_hi, s_lo;

  // WIDTH=8 instance signals
  logic        rst8 = 1'b0, t_start = 1'b0, t_hwe = 1'b0, t_lwe = 1'b0;
  logic [1:0]  t_op = '0;
  logic [7:0]  t_a = '0, t_b = '0, t_wd = '0;
  logic        t_busy, t_done, t_dz;
  logic [7:0]  t_hi, t_lo;

  sm_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst32), .start(s_start), .op(s_op), .srcA(s_a), .srcB(s_b),
    .hiWe(s_hwe), .loWe(s_lwe), .wd(s_wd), .busy(s_busy), .done(s_done),
    .divZero(s_dz), .hi(s_hi), .lo(s_lo)
  );

  sm_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8), .start(t_start), .op(t_op), .srcA(t_a), .srcB(t_b),
    .hiWe(t_hwe), .loWe(t_lwe), .wd(t_wd), .busy(t_busy), .done(t_done),
    .divZero(t_dz), .hi(t_hi), .lo(t_lo)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int acc8 [4] = '{0, 0, 0, 0};

  typedef struct {
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    logic [31:0] rhi, rlo;
    logic        rdz;
    int          rem;
  } model_t;

  model_t m32 = '{default: 0};
  model_t m8  = '{default: 0};

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : 32'((longint'(1) << w) - 1);
  endfunction

  // Architectural result of one operation at width w, from integer arithmetic
  function automatic void ref_op(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    rdz = 1'b0;
    if (op == MD_MULTU || op == MD_MULT) begin
      p   = (op == MD_MULT) ? sa * sb : ua * ub;
      rhi = 32'((p >> w) & mask);
      rlo = 32'(p & mask);
    end else if (ub == 0) begin
      rhi = a;
      rlo = 32'(mask);
      rdz = 1'b1;
    end else begin
      q   = (op == MD_DIV) ? sa / sb : ua / ub;
      r   = (op == MD_DIV) ? sa % sb : ua % ub;
      rhi = 32'(r & mask);
      rlo = 32'(q & mask);
    end
  endfunction

  // One clock edge of the unit seen from outside: idle, or counting down WIDTH+1 edges to a result
  function automatic model_t mstep(input model_t m, input int w, input logic rst, input logic st,
                                   input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic hwe, input logic lwe, input logic [31:0] wd);
    model_t n;
    logic [31:0] rh, rl;
    logic rz;
    n = m;
    if (!rst) begin
      n.busy = 0; n.done = 0; n.dz = 0; n.hi = 0; n.lo = 0; n.rem = 0;
      return n;
    end
    n.done = 0;
    if (m.rem > 0) begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.hi = m.rhi; n.lo = m.rlo; n.dz = m.rdz; n.busy = 0; n.done = 1;
      end
    end else begin
      if (hwe) n.hi = wd;
      if (lwe) n.lo = wd;
      if (st) begin
        ref_op(w, op, a, b, rh, rl, rz);
        n.rhi = rh; n.rlo = rl; n.rdz = rz;
        n.dz = 0; n.rem = w + 1; n.busy = 1;
      end
    end
    return n;
  endfunction

  // Advance both models on the same edge the DUTs see
  always @(posedge clk) begin
    if (rst8 && t_start && m8.rem == 0) acc8[t_op] = acc8[t_op] + 1;
    m32 = mstep(m32, 32, rst32, s_start, s_op, s_a, s_b, s_hwe, s_lwe, s_wd);
    m8  = mstep(m8, 8, rst8, t_start, t_op, {24'b0, t_a}, {24'b0, t_b}, t_hwe, t_lwe, {24'b0, t_wd});
  end

  task automatic cmp(input string n, input logic b, input logic d, input logic z,
                     input logic [31:0] h, input logic [31:0] l, input model_t m);
    vectors++;
    if ({b, d, z, h, l} !== {m.busy, m.done, m.dz, m.hi, m.lo}) begin
      miscompares++;
      $display("FAIL %s t=%0t busy/done/divZero/hi/lo got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
               n, $time, b, d, z, h, l, m.busy, m.done, m.dz, m.hi, m.lo);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cycle32", s_busy, s_done, s_dz, s_hi, s_lo, m32);
      cmp("cycle8", t_busy, t_done, t_dz, {24'b0, t_hi}, {24'b0, t_lo}, m8);
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", n, got, exp);
    end
  endtask

  // Called just after a negedge: present a request for one cycle
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    s_start = 1'b1; s_op = op; s_a = a; s_b = b;
    @(negedge clk);
    s_start = 1'b0; s_op = 2'($urandom); s_a = $urandom; s_b = $urandom;
  endtask

  task automatic wait_done32(output int bc);
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      if (s_done) break;
      if (s_busy) bc++;
      @(negedge clk);
    end
    chk("done_seen", {31'b0, s_done}, 32'd1);
  endtask

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int bc;
    issue32(op, a, b);
    wait_done32(bc);
  endtask

  function automatic logic [31:0] rval(input int w);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return wmask(w);
      3:       return 32'd1 << (w - 1);
      default: return $urandom & wmask(w);
    endcase
  endfunction

  initial begin
    logic [31:0] h, l;
    logic z;
    int bc, dn, mn;

    // Pin the reference arithmetic with hand-computed values
    ref_op(32, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, z);
    chk("ref_multu_hi", h, 32'hFFFF_FFFE);
    chk("ref_multu_lo", l, 32'h0000_0001);
    ref_op(8, MD_DIV, 32'h80, 32'hFF, h, l, z);
    chk("ref_div8_min_lo", l, 32'h80);
    chk("ref_div8_min_hi", h, 32'h00);
    ref_op(8, MD_DIV, 32'hF9, 32'h02, h, l, z);
    chk("ref_div8_neg_lo", l, 32'hFD);
    chk("ref_div8_neg_hi", h, 32'hFF);
    ref_op(32, MD_DIVU, 32'h1234, 32'h0, h, l, z);
    chk("ref_divz_hi", h, 32'h1234);
    chk("ref_divz_z", {31'b0, z}, 32'd1);

    @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;
    repeat (2) @(negedge clk);
    rst32 = 1'b1; rst8 = 1'b1;
    chk_en = 1'b1;
    chk("reset_busy", {31'b0, s_busy}, 32'd0);
    chk("reset_hi", s_hi, 32'd0);
    chk("reset_lo", s_lo, 32'd0);

    issue32(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32(bc);
    chk("multu_busy_cycles", 32'(bc), 32'd33);
    chk("multu_hi", s_hi, 32'hFFFF_FFFE);
    chk("multu_lo", s_lo, 32'h0000_0001);

    run32(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi", s_hi, 32'hFFFF_FFFF);
    chk("mult_lo", s_lo, 32'hFFFF_FFEB);

    run32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", s_lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", s_hi, 32'hFFFF_FFFF);

    run32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_lo", s_lo, 32'h8000_0000);
    chk("div_min_hi", s_hi, 32'h0);

    run32(MD_DIVU, 32'd100, 32'd7);
    chk("divu_lo", s_lo, 32'd14);
    chk("divu_hi", s_hi, 32'd2);
    chk("divu_dz", {31'b0, s_dz}, 32'd0);

    run32(MD_DIVU, 32'h1234, 32'h0);
    chk("divz_hi", s_hi, 32'h1234);
    chk("divz_lo", s_lo, 32'hFFFF_FFFF);
    chk("divz_dz", {31'b0, s_dz}, 32'd1);

    run32(MD_MULTU, 32'd2, 32'd3);
    chk("after_divz_dz", {31'b0, s_dz}, 32'd0);
    chk("after_divz_lo", s_lo, 32'd6);

    // Restart attempt and HI write while busy must not disturb the running multiply
    issue32(MD_MULTU, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    s_start = 1'b1; s_op = MD_DIVU; s_a = 32'd100; s_b = 32'd7; s_hwe = 1'b1; s_wd = 32'hAA;
    @(negedge clk);
    s_start = 1'b0; s_hwe = 1'b0;
    wait_done32(bc);
    chk("busy_start_hi", s_hi, 32'd0);
    chk("busy_start_lo", s_lo, 32'd25);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done) dn++;
    end
    chk("single_done", 32'(dn), 32'd0);

    s_hwe = 1'b1; s_wd = 32'hAA;
    @(negedge clk);
    s_hwe = 1'b0;
    chk("idle_mthi", s_hi, 32'hAA);
    s_lwe = 1'b1; s_wd = 32'h55;
    @(negedge clk);
    s_lwe = 1'b0;
    chk("idle_mtlo", s_lo, 32'h55);

    // Reset during a divide aborts without writing a result
    issue32(MD_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst32 = 1'b0;
    @(negedge clk);
    rst32 = 1'b1;
    chk("abort_busy", {31'b0, s_busy}, 32'd0);
    chk("abort_done", {31'b0, s_done}, 32'd0);
    chk("abort_hi", s_hi, 32'd0);
    chk("abort_lo", s_lo, 32'd0);
    run32(MD_DIVU, 32'd100, 32'd7);
    chk("post_abort_lo", s_lo, 32'd14);
    chk("post_abort_hi", s_hi, 32'd2);

    // Back-to-back: request in the done cycle
    run32(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("b2b_hi", s_hi, 32'hFFFF_FFFF);
    chk("b2b_lo", s_lo, 32'hFFFF_FFEB);

    // MTHI and start on the same idle edge: write lands, result overwrites later
    s_hwe = 1'b1; s_wd = 32'h123;
    issue32(MD_MULTU, 32'd2, 32'd3);
    s_hwe = 1'b0;
    chk("same_edge_hi", s_hi, 32'h123);
    wait_done32(bc);
    chk("same_edge_res_hi", s_hi, 32'd0);
    chk("same_edge_res_lo", s_lo, 32'd6);

    // Random traffic on both widths until every op has run 1000 times at WIDTH=8
    for (int cyc = 0; cyc < 70000; cyc++) begin
      mn = acc8[0];
      for (int k = 1; k < 4; k++) if (acc8[k] < mn) mn = acc8[k];
      if (mn >= 1000) break;
      t_start = ($urandom_range(0, 3) != 0);
      t_op    = 2'($urandom_range(0, 3));
      t_a     = 8'(rval(8));
      t_b     = 8'(rval(8));
      t_hwe   = ($urandom_range(0, 15) == 0);
      t_lwe   = ($urandom_range(0, 15) == 0);
      t_wd    = 8'($urandom);
      rst8    = ($urandom_range(0, 1999) != 0);
      s_start = ($urandom_range(0, 3) == 0);
      s_op    = 2'($urandom_range(0, 3));
      s_a     = rval(32);
      s_b     = rval(32);
      s_hwe   = ($urandom_range(0, 15) == 0);
      s_lwe   = ($urandom_range(0, 15) == 0);
      s_wd    = $urandom;
      rst32   = ($urandom_range(0, 1999) != 0);
      @(negedge clk);
    end
    mn = acc8[0];
    for (int k = 1; k < 4; k++) if (acc8[k] < mn) mn = acc8[k];
    chk("random_ops_per_op", {31'b0, (mn >= 1000)}, 32'd1);

    t_start = 1'b0; t_hwe = 1'b0; t_lwe = 1'b0; rst8 = 1'b1;
    s_start = 1'b0; s_hwe = 1'b0; s_lwe = 1'b0; rst32 = 1'b1;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
